// File: rtl/fft_frame_loader.sv
// Sample loader for the FFT ping-pong RAM: packs each accepted sample into a complex word,
// writes it into the free bank and hands finished banks to the FFT engine via ready/release.
`timescale 1ns/1ps

module fft_frame_loader #(
  parameter int ADDR_W     = 11,
  parameter int FRAME_LOG2 = 10
) (
  input  logic              clk_50mhz_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic              sample_strobe,
  input  logic [15:0]       sample_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              frame_ready,
  output logic              frame_bank,
  input  logic              frame_release,
  output logic [7:0]        drop_count
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_BANK} state_e;

  state_e                  state_q, state_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [FRAME_LOG2-1:0]   idx_q, idx_d;
  logic [1:0]              full_q, full_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    commit_q, commit_d;
  logic                    commit_bank_q, commit_bank_d;
  logic [7:0]              drop_q, drop_d;
  logic                    wr_q, wr_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [15:0]             data_q, data_d;

  logic release_ok;
  logic cur_free;
  logic nxt_free;

  // A bank counts as free if it is empty now or is being released in this very cycle.
  assign release_ok = frame_release && full_q[rd_bank_q];
  assign cur_free   = !full_q[wr_bank_q]  || (release_ok && (rd_bank_q == wr_bank_q));
  assign nxt_free   = !full_q[!wr_bank_q] || (release_ok && (rd_bank_q == !wr_bank_q));

  always_ff @(posedge clk_50mhz_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      wr_bank_q     <= 1'b0;
      idx_q         <= '0;
      full_q        <= 2'b00;
      rd_bank_q     <= 1'b0;
      commit_q      <= 1'b0;
      commit_bank_q <= 1'b0;
      drop_q        <= 8'd0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= 16'd0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      idx_q         <= idx_d;
      full_q        <= full_d;
      rd_bank_q     <= rd_bank_d;
      commit_q      <= commit_d;
      commit_bank_q <= commit_bank_d;
      drop_q        <= drop_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    idx_d         = idx_q;
    full_d        = full_q;
    rd_bank_d     = rd_bank_q;
    commit_d      = 1'b0;
    commit_bank_d = commit_bank_q;
    drop_d        = drop_q;
    wr_d          = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;

    // Commit lands one cycle after the final write so the RAM holds the word before ready rises.
    if (commit_q) full_d[commit_bank_q] = 1'b1;
    if (release_ok) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          idx_d   = '0;
          state_d = cur_free ? FILL : WAIT_BANK;
        end
      end
      FILL: begin
        if (sample_strobe) begin
          wr_d                  = 1'b1;
          addr_d                = '0;
          addr_d[FRAME_LOG2:0]  = {wr_bank_q, idx_q};
          data_d                = sample_data;
          if (idx_q == {FRAME_LOG2{1'b1}}) begin
            commit_d      = 1'b1;
            commit_bank_d = wr_bank_q;
            wr_bank_d     = !wr_bank_q;
            idx_d         = '0;
            state_d       = nxt_free ? FILL : WAIT_BANK;
          end else begin
            idx_d = idx_q + FRAME_LOG2'(1);
          end
        end
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      WAIT_BANK: begin
        if (sample_strobe && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        if (cur_free) begin
          state_d = FILL;
          idx_d   = '0;
        end
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = wr_q;
  assign mem_clken      = wr_q;
  assign mem_write      = wr_q;
  assign mem_writedata  = {data_q, 16'h0000};
  assign mem_byteenable = {4{wr_q}};
  assign frame_ready    = full_q[rd_bank_q];
  assign frame_bank     = rd_bank_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader with 8-sample frames: fill, bank wait/drop,
// release handoff, enable drop-out, async reset and drop counter saturation.
`timescale 1ns/1ps

module tb_fft_frame_loader;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic        sampleStrobe;
  logic [15:0] sampleData;
  logic        frameRelease;
  logic [10:0] memAddress;
  logic        memChipselect;
  logic        memClken;
  logic        memWrite;
  logic [31:0] memWritedata;
  logic [3:0]  memByteenable;
  logic        frameReady;
  logic        frameBank;
  logic [7:0]  dropCount;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  fft_frame_loader #(.ADDR_W(11), .FRAME_LOG2(3)) dut (
    .clk_50mhz_clk (clk),
    .reset_reset_n (rstN),
    .enable        (enable),
    .sample_strobe (sampleStrobe),
    .sample_data   (sampleData),
    .mem_address   (memAddress),
    .mem_chipselect(memChipselect),
    .mem_clken     (memClken),
    .mem_write     (memWrite),
    .mem_writedata (memWritedata),
    .mem_byteenable(memByteenable),
    .frame_ready   (frameReady),
    .frame_bank    (frameBank),
    .frame_release (frameRelease),
    .drop_count    (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land just after the capturing edge for sampling.
  task automatic applyStimulus(input logic stb, input logic [15:0] data, input logic rel);
    sampleStrobe = stb;
    sampleData   = data;
    frameRelease = rel;
    @(posedge clk);
    #1;
    sampleStrobe = 1'b0;
    frameRelease = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic [10:0] addr, input logic [15:0] data);
    checkOutput({tag, " write"}, {31'd0, memWrite}, 32'd1);
    checkOutput({tag, " addr"}, {21'd0, memAddress}, {21'd0, addr});
    checkOutput({tag, " data"}, memWritedata, {data, 16'h0000});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN         = 1'b0;
    enable       = 1'b0;
    sampleStrobe = 1'b0;
    sampleData   = 16'd0;
    frameRelease = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst write",  {31'd0, memWrite}, 32'd0);
    checkOutput("rst cs",     {31'd0, memChipselect}, 32'd0);
    checkOutput("rst clken",  {31'd0, memClken}, 32'd0);
    checkOutput("rst addr",   {21'd0, memAddress}, 32'd0);
    checkOutput("rst data",   memWritedata, 32'd0);
    checkOutput("rst be",     {28'd0, memByteenable}, 32'd0);
    checkOutput("rst ready",  {31'd0, frameReady}, 32'd0);
    checkOutput("rst bank",   {31'd0, frameBank}, 32'd0);
    checkOutput("rst drops",  {24'd0, dropCount}, 32'd0);

    rstN = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0);
    enable = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0);

    $display("[TB] fill bank 0");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0);
      checkWrite($sformatf("b0[%0d]", i), 11'(i - 1), 16'(i));
      checkOutput($sformatf("b0[%0d] be", i), {28'd0, memByteenable}, 32'hF);
    end
    checkOutput("ready before commit", {31'd0, frameReady}, 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b0);
    checkOutput("ready after commit", {31'd0, frameReady}, 32'd1);
    checkOutput("bank after commit", {31'd0, frameBank}, 32'd0);
    checkOutput("idle write", {31'd0, memWrite}, 32'd0);
    checkOutput("idle be", {28'd0, memByteenable}, 32'd0);

    $display("[TB] fill bank 1 then drop");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'h0010 + 16'(i), 1'b0);
      checkWrite($sformatf("b1[%0d]", i), 11'(8 + i), 16'h0010 + 16'(i));
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'h0AAA, 1'b0);
      checkOutput($sformatf("drop[%0d] write", i), {31'd0, memWrite}, 32'd0);
    end
    checkOutput("drops=5", {24'd0, dropCount}, 32'd5);
    checkOutput("ready while waiting", {31'd0, frameReady}, 32'd1);
    checkOutput("bank while waiting", {31'd0, frameBank}, 32'd0);

    $display("[TB] release bank 0");
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("bank after release", {31'd0, frameBank}, 32'd1);
    checkOutput("ready after release", {31'd0, frameReady}, 32'd1);
    applyStimulus(1'b1, 16'h0100, 1'b0);
    checkWrite("resume", 11'd0, 16'h0100);

    $display("[TB] final write with simultaneous release");
    for (int j = 1; j <= 7; j++) begin
      applyStimulus(1'b1, 16'h0200 + 16'(j), (j == 7));
      checkWrite($sformatf("b0b[%0d]", j), 11'(j), 16'h0200 + 16'(j));
    end
    checkOutput("race bank", {31'd0, frameBank}, 32'd0);
    checkOutput("race ready", {31'd0, frameReady}, 32'd0);
    checkOutput("race drops", {24'd0, dropCount}, 32'd5);
    applyStimulus(1'b1, 16'h0300, 1'b0);
    checkWrite("race next", 11'd8, 16'h0300);
    checkOutput("race ready later", {31'd0, frameReady}, 32'd1);

    $display("[TB] release while not ready");
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("rel0 bank", {31'd0, frameBank}, 32'd1);
    checkOutput("rel0 ready", {31'd0, frameReady}, 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("ignored rel bank", {31'd0, frameBank}, 32'd1);
    checkOutput("ignored rel ready", {31'd0, frameReady}, 32'd0);

    $display("[TB] enable drop-out mid frame");
    for (int j = 1; j <= 3; j++) begin
      applyStimulus(1'b1, 16'h0310 + 16'(j), 1'b0);
      checkWrite($sformatf("part[%0d]", j), 11'(8 + j), 16'h0310 + 16'(j));
    end
    enable = 1'b0;
    applyStimulus(1'b1, 16'h0400, 1'b0);
    checkWrite("disable strobe", 11'd12, 16'h0400);
    applyStimulus(1'b1, 16'h0401, 1'b0);
    checkOutput("idle strobe", {31'd0, memWrite}, 32'd0);
    enable = 1'b1;
    applyStimulus(1'b1, 16'h0402, 1'b0);
    checkOutput("enable-edge strobe", {31'd0, memWrite}, 32'd0);
    checkOutput("enable-edge drops", {24'd0, dropCount}, 32'd5);
    applyStimulus(1'b1, 16'h0500, 1'b0);
    checkWrite("re-enable", 11'd8, 16'h0500);

    $display("[TB] asynchronous reset mid frame");
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst write", {31'd0, memWrite}, 32'd0);
    checkOutput("arst cs",    {31'd0, memChipselect}, 32'd0);
    checkOutput("arst addr",  {21'd0, memAddress}, 32'd0);
    checkOutput("arst data",  memWritedata, 32'd0);
    checkOutput("arst be",    {28'd0, memByteenable}, 32'd0);
    checkOutput("arst ready", {31'd0, frameReady}, 32'd0);
    checkOutput("arst bank",  {31'd0, frameBank}, 32'd0);
    checkOutput("arst drops", {24'd0, dropCount}, 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0);
    checkWrite("sat fill last", 11'd15, 16'h100F);
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b1, 16'h7FFF, 1'b0);
      if (i == 200) checkOutput("drops=200", {24'd0, dropCount}, 32'd200);
    end
    checkOutput("drops saturated", {24'd0, dropCount}, 32'd255);
    checkOutput("sat no write", {31'd0, memWrite}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Upstream write stage for the FFT sample RAM. It sits on the 50 MHz domain and takes single-cycle sample strobes from the 9600 Hz acquisition path. Each accepted sample is packed into a 32-bit complex word and written sequentially into one half of the dual-port RAM through its s1 port. The RAM is used as a ping-pong pair of frame banks, so the FFT engine reads one completed frame while the loader fills the other. Bank handoff uses a frame_ready / frame_release handshake.

## Interface
- ADDR_W, 11: RAM word-address width.
- FRAME_LOG2, 10: log2 of samples per frame; legal range 1..ADDR_W-1.
- clk_50mhz_clk  in  1  sole clock, rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable (level).
- sample_strobe  in  1  one-cycle pulse, sample_data valid; no backpressure.
- sample_data  in  16  signed sample.
- mem_address  out  ADDR_W  word address {zeros, bank, idx[FRAME_LOG2-1:0]}.
- mem_chipselect, mem_clken, mem_write  out  1 each  write pulse; all three equal.
- mem_writedata  out  32  {sample_data, 16'h0000}: real in [31:16], imaginary 0.
- mem_byteenable  out  4  4'hF during a write, 4'h0 otherwise.
- frame_ready  out  1  full[rd_bank].
- frame_bank  out  1  rd_bank, the oldest completed bank.
- frame_release  in  1  one-cycle pulse from the FFT engine freeing frame_bank.
- drop_count  out  8  saturating count of dropped strobes.

## Operation
- State: FSM {IDLE, FILL, WAIT_BANK}, wr_bank, idx, full[1:0], rd_bank, commit pipeline flag, drop_count.
- Reset values: all zero; state is IDLE. Every mem_* output is 0 and frame_ready is 0.
- IDLE:
  - Strobes are ignored and not counted.
  - When enable=1, go to FILL with idx=0 if full[wr_bank]=0, else go to WAIT_BANK.
- FILL, strobe accepted:
  - Register the write at address {wr_bank, idx} and increment idx.
  - On the final sample (idx = 2^FRAME_LOG2 - 1):
    - schedule commit of full[wr_bank];
    - toggle wr_bank and set idx=0;
    - stay in FILL if the new bank is free (using that cycle's release), else go to WAIT_BANK.
- WAIT_BANK:
  - Every strobe is dropped and drop_count increments, saturating at 255.
  - Go to FILL with idx=0 once full[wr_bank] clears.
- enable deasserts in FILL or WAIT_BANK:
  - Go to IDLE on the next edge and reset idx to 0.
  - The partial frame is discarded; wr_bank and full are unchanged.
  - A strobe in that same cycle is still written.
- Handoff:
  - frame_release is honoured only if frame_ready=1 in that cycle.
  - An honoured release clears full[rd_bank] and toggles rd_bank.
  - A release while frame_ready=0 is ignored.
- Simultaneous events:
  - Final write of bank b plus release of ~b: the release wins, and FILL continues directly on ~b with no drop.
  - Release plus commit always target different banks, so no conflict.
- drop_count is cleared only by reset.

## Timing
- Strobe in cycle t (FILL): mem_write, address and data are valid for exactly cycle t+1. Write latency is 1.
- Final write issued in t+1: full[b] sets at the t+2 edge, so frame_ready rises in t+2, after the RAM has captured the word.
- Release in cycle r: frame_ready falls and frame_bank toggles at r+1. If the loader was waiting on that bank, it is in FILL at r+1 and accepts a strobe at r+1.
- Strobe in the same cycle as enable rising: ignored, since the FSM is still in IDLE.
- Back-to-back strobes every cycle are supported in FILL with no gaps.

## Test plan
- FRAME_LOG2=3, enable=1, 8 strobes of data 0x0001..0x0008:
  - required: writes to addresses 0..7 with data 0x00010000..0x00080000 and byteenable F;
  - required: frame_ready=1 two cycles after the 8th strobe, frame_bank=0.
- Continue with 8 more strobes, no release:
  - required: writes to addresses 8..15, then WAIT_BANK;
  - next 5 strobes: no writes, drop_count=5.
  - Then pulse release: frame_bank=1, the next strobe writes address 0.
- Final strobe of bank 1 in the same cycle as the release of bank 0: required no drop, and the next strobe writes address 0.
- Release pulse while frame_ready=0: required no change to frame_bank or full.
- Deassert enable after 5 samples, re-enable: required the next write goes to {wr_bank, 0}.
- Assert reset mid-frame: required all outputs 0 immediately, asynchronously.
- 300 drops: required drop_count saturates at 255.
